// File: rtl/execute_pipe.sv
// Pipelined MIPS execute stage: ALU, branch target and destination select feeding a
// registered EX/MEM beat under valid/ready, plus an iterative MULTU with HI/LO.
module execute_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              alu_src,
    input  logic [1:0]        alu_op,
    input  logic              reg_dst,
    input  logic [DATA_W-1:0] pc_next,
    input  logic [DATA_W-1:0] branch_imm,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] pc_branch,
    output logic              alu_zero,
    output logic [DATA_W-1:0] alu_res,
    output logic [REG_AW-1:0] write_reg
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;

    function automatic logic [DATA_W-1:0] alu_calc(
        input logic [1:0]        op,
        input logic [5:0]        fn,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] hi_v,
        input logic [DATA_W-1:0] lo_v
    );
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] b_s;
        logic [DATA_W-1:0]        r;
        a_s = $signed(a);
        b_s = $signed(b);
        r   = a + b;
        case (op)
            2'b01: r = a - b;
            2'b10: begin
                case (fn)
                    FN_ADD:   r = a + b;
                    FN_SUB:   r = a - b;
                    FN_AND:   r = a & b;
                    FN_OR:    r = a | b;
                    FN_SLT:   r = (a_s < b_s) ? DATA_W'(1) : '0;
                    FN_MFHI:  r = hi_v;
                    FN_MFLO:  r = lo_v;
                    FN_MULTU: r = '0;
                    default:  r = a + b;
                endcase
            end
            default: r = a + b;
        endcase
        return r;
    endfunction

    logic              busy;
    logic [CNT_W-1:0]  mul_cnt;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W-1:0] acc_lo_nxt;

    logic              accept_p0;
    logic              is_multu_p0;
    logic [DATA_W-1:0] op_b_p0;
    logic [DATA_W-1:0] res_p0;
    logic [DATA_W-1:0] pcb_p0;
    logic [REG_AW-1:0] wreg_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] pcb_p1;
    logic              zero_p1;
    logic [DATA_W-1:0] res_p1;
    logic [REG_AW-1:0] wreg_p1;

    // Stage p0: combinational execute on the ID/EX inputs
    assign in_ready    = !busy && (!vld_p1 || out_ready);
    assign accept_p0   = in_valid && in_ready && !flush;
    assign is_multu_p0 = (alu_op == 2'b10) && (branch_imm[5:0] == FN_MULTU);
    assign op_b_p0     = alu_src ? branch_imm : rt_data;
    assign res_p0      = alu_calc(alu_op, branch_imm[5:0], rs_data, op_b_p0, hi, lo);
    assign pcb_p0      = pc_next + (branch_imm << 2);
    assign wreg_p0     = is_multu_p0 ? '0 : (reg_dst ? rd : rt);

    // One shift-add step per cycle: {acc_hi, acc_lo} becomes the product after DATA_W steps
    assign mul_sum    = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mcand : '0)};
    assign acc_lo_nxt = {mul_sum[0], acc_lo[DATA_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            mul_cnt <= '0;
            hi      <= '0;
            lo      <= '0;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else if (flush) begin
            busy    <= 1'b0;
            mul_cnt <= '0;
        end else if (accept_p0 && is_multu_p0) begin
            busy    <= 1'b1;
            mul_cnt <= '0;
            mcand   <= rs_data;
            acc_hi  <= '0;
            acc_lo  <= rt_data;
        end else if (busy) begin
            acc_hi  <= mul_sum[DATA_W:1];
            acc_lo  <= acc_lo_nxt;
            mul_cnt <= mul_cnt + CNT_W'(1);
            if (mul_cnt == CNT_W'(DATA_W - 1)) begin
                busy    <= 1'b0;
                mul_cnt <= '0;
                hi      <= mul_sum[DATA_W:1];
                lo      <= acc_lo_nxt;
            end
        end
    end

    // Stage p1: EX/MEM output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            pcb_p1  <= '0;
            zero_p1 <= 1'b0;
            res_p1  <= '0;
            wreg_p1 <= '0;
        end else begin
            if (flush)
                vld_p1 <= 1'b0;
            else if (accept_p0)
                vld_p1 <= 1'b1;
            else if (out_ready)
                vld_p1 <= 1'b0;
            if (accept_p0) begin
                pcb_p1  <= pcb_p0;
                zero_p1 <= (res_p0 == '0);
                res_p1  <= res_p0;
                wreg_p1 <= wreg_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign pc_branch = pcb_p1;
    assign alu_zero  = zero_p1;
    assign alu_res   = res_p1;
    assign write_reg = wreg_p1;

endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe: expected beats are queued on accept and
// compared as each output beat is handed downstream.
module tb_execute_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        reg_dst;
    logic [31:0] pc_next;
    logic [31:0] branch_imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_branch;
    logic        alu_zero;
    logic [31:0] alu_res;
    logic [4:0]  write_reg;

    execute_pipe #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_src(alu_src), .alu_op(alu_op), .reg_dst(reg_dst), .pc_next(pc_next),
        .branch_imm(branch_imm), .rs_data(rs_data), .rt_data(rt_data), .rt(rt), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .pc_branch(pc_branch),
        .alu_zero(alu_zero), .alu_res(alu_res), .write_reg(write_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  wreg;
        logic [31:0] pcb;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          wt;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] sv_hi;
    logic [31:0] sv_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [5:0] fn,
                                              input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        if (fn == 6'h22) return a - b;
        if (fn == 6'h24) return a & b;
        if (fn == 6'h25) return a | b;
        if (fn == 6'h2A) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (fn == 6'h10) return m_hi;
        if (fn == 6'h12) return m_lo;
        if (fn == 6'h19) return 32'd0;
        return a + b;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("alu_res", alu_res, mon_e.res);
                check("alu_zero", alu_zero, mon_e.zero);
                check("write_reg", write_reg, mon_e.wreg);
                check("pc_branch", pc_branch, mon_e.pcb);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic src, input logic dst,
                        input logic [31:0] pcn, input logic [31:0] imm,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rt_i, input logic [4:0] rd_i, output int waited);
        exp_t        e;
        logic [31:0] ob;
        logic        mu;
        logic        ok;
        alu_op = op; alu_src = src; reg_dst = dst; pc_next = pcn; branch_imm = imm;
        rs_data = a; rt_data = b; rt = rt_i; rd = rd_i; in_valid = 1'b1;
        ob     = src ? imm : b;
        mu     = (op == 2'b10) && (imm[5:0] == 6'h19);
        e.res  = model_alu(op, imm[5:0], a, ob);
        e.zero = (e.res == 32'd0);
        e.wreg = mu ? 5'd0 : (dst ? rd_i : rt_i);
        e.pcb  = pcn + (imm << 2);
        waited = 0;
        ok     = 1'b0;
        while (!ok && waited <= 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            check("accept_timeout", 64'(waited), 64'd0);
        end else begin
            sb.push_back(e);
            if (mu) {m_hi, m_lo} = 64'(a) * 64'(b);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_src = 1'b0; alu_op = 2'b00;
        reg_dst = 1'b0; pc_next = '0; branch_imm = '0; rs_data = '0; rt_data = '0;
        rt = '0; rd = '0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_res", alu_res, 0);
        check("rst_pc_branch", pc_branch, 0);
        check("rst_alu_zero", alu_zero, 0);
        check("rst_write_reg", write_reg, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // ALU patterns
        send(2'b10, 1'b0, 1'b1, 32'h200, 32'h20, 32'd5, 32'd7, 5'd3, 5'd9, wt);
        check("add_latency", out_valid, 1);
        send(2'b01, 1'b0, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h1234, 32'h1234, 5'd4, 5'd0, wt);
        check("throughput_wait", 64'(wt), 0);
        send(2'b10, 1'b0, 1'b1, 32'h0, 32'h2A, 32'hFFFF_FFFF, 32'd1, 5'd1, 5'd2, wt);
        send(2'b10, 1'b0, 1'b1, 32'h0, 32'h2A, 32'd1, 32'hFFFF_FFFF, 5'd1, 5'd2, wt);
        send(2'b10, 1'b0, 1'b1, 32'h40, 32'h24, 32'hF0F0, 32'h0FF0, 5'd5, 5'd6, wt);
        send(2'b10, 1'b0, 1'b1, 32'h40, 32'h25, 32'hF0F0, 32'h0FF0, 5'd5, 5'd7, wt);
        send(2'b10, 1'b0, 1'b1, 32'h40, 32'h3F, 32'd10, 32'd20, 5'd5, 5'd8, wt);
        send(2'b11, 1'b0, 1'b0, 32'h40, 32'h0, 32'hFFFF_FFFF, 32'd1, 5'd11, 5'd8, wt);
        send(2'b00, 1'b1, 1'b0, 32'h80, 32'h10, 32'd5, 32'd99, 5'd12, 5'd8, wt);

        // MULTU then dependent MFHI / MFLO
        send(2'b10, 1'b0, 1'b1, 32'h300, 32'h19, 32'hFFFF_FFFF, 32'd2, 5'd1, 5'd2, wt);
        send(2'b10, 1'b0, 1'b1, 32'h304, 32'h10, 32'd0, 32'd0, 5'd0, 5'd13, wt);
        check("multu_busy_cycles", 64'(wt), 64'd32);
        send(2'b10, 1'b0, 1'b1, 32'h308, 32'h12, 32'd0, 32'd0, 5'd0, 5'd14, wt);

        // Backpressure: second instruction waits while first beat is held
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        send(2'b00, 1'b0, 1'b1, 32'h400, 32'h0, 32'd1, 32'd2, 5'd0, 5'd10, wt);
        fork
            send(2'b01, 1'b0, 1'b1, 32'h404, 32'h0, 32'd9, 32'd4, 5'd0, 5'd11, wt);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold_res", alu_res, 32'd3);
                    check("bp_hold_wreg", write_reg, 5'd10);
                    check("bp_valid", out_valid, 1);
                    check("bp_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join

        // Flush mid-multiply: HI/LO keep the earlier product
        sv_hi = m_hi; sv_lo = m_lo;
        send(2'b10, 1'b0, 1'b1, 32'h500, 32'h19, 32'd7, 32'd9, 5'd1, 5'd2, wt);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_mul_ovalid", out_valid, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy_clear", in_ready, 1);
        check("flush_ovalid_after", out_valid, 0);
        m_hi = sv_hi; m_lo = sv_lo;
        send(2'b10, 1'b0, 1'b1, 32'h504, 32'h10, 32'd0, 32'd0, 5'd0, 5'd15, wt);
        check("flush_no_wait", 64'(wt), 0);
        send(2'b10, 1'b0, 1'b1, 32'h508, 32'h12, 32'd0, 32'd0, 5'd0, 5'd16, wt);

        // Flush wins over a simultaneous valid input
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        send(2'b00, 1'b0, 1'b1, 32'h600, 32'h0, 32'd20, 32'd22, 5'd0, 5'd17, wt);
        alu_op = 2'b01; alu_src = 1'b0; rs_data = 32'd50; rt_data = 32'd8; rd = 5'd18;
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        check("flush_drop_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        check("flush_drop_still", out_valid, 0);
        check("flush_drop_res", alu_res, 32'd42);

        // Asynchronous reset in the middle of a held beat
        out_ready = 1'b0;
        send(2'b00, 1'b0, 1'b1, 32'h700, 32'h0, 32'd100, 32'd1, 5'd0, 5'd19, wt);
        check("pre_rst_res", alu_res, 32'd101);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_alu_res", alu_res, 0);
        check("arst_pc_branch", pc_branch, 0);
        check("arst_alu_zero", alu_zero, 0);
        check("arst_write_reg", write_reg, 0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        m_hi = '0; m_lo = '0;
        send(2'b10, 1'b0, 1'b1, 32'h800, 32'h10, 32'd0, 32'd0, 5'd0, 5'd20, wt);
        send(2'b10, 1'b0, 1'b1, 32'h804, 32'h12, 32'd0, 32'd0, 5'd0, 5'd21, wt);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end
endmodule
